// File: rtl/ysyx_25030093_axi_pkg.sv
// rtl/ysyx_25030093_axi_pkg.sv - shared state enums, response codes and address map for the xbar
package ysyx_25030093_axi_pkg;

  localparam logic [1:0] RESP_OKAY   = 2'b00;
  localparam logic [1:0] RESP_DECERR = 2'b11;

  localparam logic [31:0] UART_BASE_DEF = 32'ha000_03f8;
  localparam logic [31:0] UART_SIZE_DEF = 32'h0000_0008;
  localparam logic [31:0] SRAM_BASE_DEF = 32'h8000_0000;
  localparam logic [31:0] SRAM_SIZE_DEF = 32'h0800_0000;

  typedef enum logic [1:0] {R_IDLE, R_ADDR, R_DATA, R_ERR} r_state_t;
  typedef enum logic [1:0] {W_IDLE, W_FWD, W_RESP, W_ERR} w_state_t;

endpackage

// File: rtl/ysyx_25030093_xbar_dec.sv
// rtl/ysyx_25030093_xbar_dec.sv - address decoder: UART window, SRAM window, or decode error
module ysyx_25030093_xbar_dec
  import ysyx_25030093_axi_pkg::*;
#(
  parameter logic [31:0] UART_BASE = UART_BASE_DEF,
  parameter logic [31:0] UART_SIZE = UART_SIZE_DEF,
  parameter logic [31:0] SRAM_BASE = SRAM_BASE_DEF,
  parameter logic [31:0] SRAM_SIZE = SRAM_SIZE_DEF
) (
  input  logic [31:0] addr,
  output logic        sel_uart,
  output logic        sel_sram,
  output logic        err
);

  logic [32:0] uart_end;
  logic [32:0] sram_end;
  logic        hit_uart;
  logic        hit_sram;

  // 33-bit window ends so a window touching the top of the map cannot wrap
  assign uart_end = {1'b0, UART_BASE} + {1'b0, UART_SIZE};
  assign sram_end = {1'b0, SRAM_BASE} + {1'b0, SRAM_SIZE};

  assign hit_uart = (addr >= UART_BASE) && ({1'b0, addr} < uart_end);
  assign hit_sram = (addr >= SRAM_BASE) && ({1'b0, addr} < sram_end);

  assign sel_uart = hit_uart;
  assign sel_sram = hit_sram && !hit_uart;
  assign err      = !hit_uart && !hit_sram;

endmodule

// File: rtl/ysyx_25030093_xbar.sv
// rtl/ysyx_25030093_xbar.sv - one-master, two-slave (UART, SRAM) AXI-lite crossbar
// Independent read and write FSMs, one outstanding transaction each; misses answer DECERR.
module ysyx_25030093_xbar
  import ysyx_25030093_axi_pkg::*;
#(
  parameter logic [31:0] UART_BASE = UART_BASE_DEF,
  parameter logic [31:0] UART_SIZE = UART_SIZE_DEF,
  parameter logic [31:0] SRAM_BASE = SRAM_BASE_DEF,
  parameter logic [31:0] SRAM_SIZE = SRAM_SIZE_DEF
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic [31:0] M_araddr,
  input  logic        M_arvalid,
  output logic        M_arready,
  output logic [31:0] M_rdata,
  output logic [1:0]  M_rresp,
  output logic        M_rvalid,
  input  logic        M_rready,
  input  logic [31:0] M_awaddr,
  input  logic        M_awvalid,
  output logic        M_awready,
  input  logic [31:0] M_wdata,
  input  logic [7:0]  M_wstrb,
  input  logic        M_wvalid,
  output logic        M_wready,
  output logic [1:0]  M_bresp,
  output logic        M_bvalid,
  input  logic        M_bready,
  output logic [31:0] UART_araddr,
  output logic        UART_arvalid,
  input  logic        UART_arready,
  input  logic [31:0] UART_rdata,
  input  logic        UART_rvalid,
  output logic        UART_rready,
  output logic [31:0] UART_awaddr,
  output logic        UART_awvalid,
  input  logic        UART_awready,
  output logic [31:0] UART_wdata,
  output logic [7:0]  UART_wstrb,
  output logic        UART_wvalid,
  input  logic        UART_wready,
  input  logic        UART_bvalid,
  output logic        UART_bready,
  output logic [31:0] SRAM_araddr,
  output logic        SRAM_arvalid,
  input  logic        SRAM_arready,
  input  logic [31:0] SRAM_rdata,
  input  logic        SRAM_rvalid,
  output logic        SRAM_rready,
  output logic [31:0] SRAM_awaddr,
  output logic        SRAM_awvalid,
  input  logic        SRAM_awready,
  output logic [31:0] SRAM_wdata,
  output logic [7:0]  SRAM_wstrb,
  output logic        SRAM_wvalid,
  input  logic        SRAM_wready,
  input  logic        SRAM_bvalid,
  output logic        SRAM_bready
);

  logic rd_sel_uart, rd_sel_sram, rd_err;
  logic wr_sel_uart, wr_sel_sram, wr_err;

  ysyx_25030093_xbar_dec #(
    .UART_BASE(UART_BASE), .UART_SIZE(UART_SIZE),
    .SRAM_BASE(SRAM_BASE), .SRAM_SIZE(SRAM_SIZE)
  ) u_rd_dec (
    .addr(M_araddr), .sel_uart(rd_sel_uart), .sel_sram(rd_sel_sram), .err(rd_err)
  );

  ysyx_25030093_xbar_dec #(
    .UART_BASE(UART_BASE), .UART_SIZE(UART_SIZE),
    .SRAM_BASE(SRAM_BASE), .SRAM_SIZE(SRAM_SIZE)
  ) u_wr_dec (
    .addr(M_awaddr), .sel_uart(wr_sel_uart), .sel_sram(wr_sel_sram), .err(wr_err)
  );

  r_state_t    r_state;
  logic [31:0] r_addr;
  logic        r_uart, r_sram;
  logic        sel_arready, sel_rvalid;

  assign sel_arready = (r_uart && UART_arready) || (r_sram && SRAM_arready);
  assign sel_rvalid  = (r_uart && UART_rvalid) || (r_sram && SRAM_rvalid);

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state <= R_IDLE;
      r_addr  <= '0;
      r_uart  <= 1'b0;
      r_sram  <= 1'b0;
    end else begin
      case (r_state)
        R_IDLE: if (M_arvalid) begin
          r_addr  <= M_araddr;
          r_uart  <= rd_sel_uart;
          r_sram  <= rd_sel_sram;
          r_state <= rd_err ? R_ERR : R_ADDR;
        end
        R_ADDR:  if (sel_arready) r_state <= R_DATA;
        R_DATA:  if (sel_rvalid && M_rready) r_state <= R_IDLE;
        R_ERR:   if (M_rready) r_state <= R_IDLE;
        default: r_state <= R_IDLE;
      endcase
    end
  end

  // rst_n gates arready so the master sees no ready while reset is held
  assign M_arready    = rst_n && (r_state == R_IDLE);
  assign UART_araddr  = r_addr;
  assign SRAM_araddr  = r_addr;
  assign UART_arvalid = (r_state == R_ADDR) && r_uart;
  assign SRAM_arvalid = (r_state == R_ADDR) && r_sram;
  assign UART_rready  = (r_state == R_DATA) && r_uart && M_rready;
  assign SRAM_rready  = (r_state == R_DATA) && r_sram && M_rready;

  always_comb begin
    M_rvalid = 1'b0;
    M_rdata  = '0;
    M_rresp  = RESP_OKAY;
    case (r_state)
      R_DATA: begin
        M_rvalid = sel_rvalid;
        M_rdata  = r_uart ? UART_rdata : SRAM_rdata;
      end
      R_ERR: begin
        M_rvalid = 1'b1;
        M_rresp  = RESP_DECERR;
      end
      default: ;
    endcase
  end

  w_state_t    w_state;
  logic [31:0] w_addr, w_data;
  logic [7:0]  w_strb;
  logic        w_uart, w_sram;
  logic        aw_done, w_done;
  logic        aw_pend, w_pend, aw_fire, w_fire, sel_bvalid;

  assign aw_pend    = (w_state == W_FWD) && !aw_done;
  assign w_pend     = (w_state == W_FWD) && !w_done;
  assign aw_fire    = aw_pend && ((w_uart && UART_awready) || (w_sram && SRAM_awready));
  assign w_fire     = w_pend && ((w_uart && UART_wready) || (w_sram && SRAM_wready));
  assign sel_bvalid = (w_uart && UART_bvalid) || (w_sram && SRAM_bvalid);

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      w_state <= W_IDLE;
      w_addr  <= '0;
      w_data  <= '0;
      w_strb  <= '0;
      w_uart  <= 1'b0;
      w_sram  <= 1'b0;
      aw_done <= 1'b0;
      w_done  <= 1'b0;
    end else begin
      case (w_state)
        W_IDLE: if (M_awvalid && M_wvalid) begin
          w_addr  <= M_awaddr;
          w_data  <= M_wdata;
          w_strb  <= M_wstrb;
          w_uart  <= wr_sel_uart;
          w_sram  <= wr_sel_sram;
          aw_done <= 1'b0;
          w_done  <= 1'b0;
          w_state <= wr_err ? W_ERR : W_FWD;
        end
        W_FWD: begin
          if (aw_fire) aw_done <= 1'b1;
          if (w_fire)  w_done  <= 1'b1;
          if ((aw_done || aw_fire) && (w_done || w_fire)) w_state <= W_RESP;
        end
        W_RESP:  if (sel_bvalid && M_bready) w_state <= W_IDLE;
        W_ERR:   if (M_bready) w_state <= W_IDLE;
        default: w_state <= W_IDLE;
      endcase
    end
  end

  assign M_awready    = rst_n && (w_state == W_IDLE) && M_awvalid && M_wvalid;
  assign M_wready     = M_awready;
  assign UART_awaddr  = w_addr;
  assign SRAM_awaddr  = w_addr;
  assign UART_wdata   = w_data;
  assign SRAM_wdata   = w_data;
  assign UART_wstrb   = w_strb;
  assign SRAM_wstrb   = w_strb;
  assign UART_awvalid = aw_pend && w_uart;
  assign SRAM_awvalid = aw_pend && w_sram;
  assign UART_wvalid  = w_pend && w_uart;
  assign SRAM_wvalid  = w_pend && w_sram;
  assign UART_bready  = (w_state == W_RESP) && w_uart && M_bready;
  assign SRAM_bready  = (w_state == W_RESP) && w_sram && M_bready;

  assign M_bvalid = ((w_state == W_RESP) && sel_bvalid) || (w_state == W_ERR);
  assign M_bresp  = (w_state == W_ERR) ? RESP_DECERR : RESP_OKAY;

endmodule

// File: tb/tb_ysyx_25030093_xbar.sv
// tb/tb_ysyx_25030093_xbar.sv - randomized bench for the xbar against a transaction-level model
module tb_ysyx_25030093_xbar;

  localparam int NONE = 3;
  localparam int ERR  = 2;

  typedef struct packed {logic id; logic [31:0] addr;} rd_ent_t;
  typedef struct packed {logic id; logic [31:0] addr; logic [31:0] data; logic [7:0] strb;} wr_ent_t;

  logic clk, rst_n;
  logic [31:0] M_araddr, M_rdata, M_awaddr, M_wdata;
  logic        M_arvalid, M_arready, M_rvalid, M_rready;
  logic [1:0]  M_rresp, M_bresp;
  logic        M_awvalid, M_awready, M_wvalid, M_wready, M_bvalid, M_bready;
  logic [7:0]  M_wstrb;

  logic [31:0] s_araddr [2], s_rdata [2], s_awaddr [2], s_wdata [2];
  logic [7:0]  s_wstrb [2];
  logic        s_arvalid [2], s_arready [2], s_rvalid [2], s_rready [2];
  logic        s_awvalid [2], s_awready [2], s_wvalid [2], s_wready [2];
  logic        s_bvalid [2], s_bready [2];
  logic        stall_ar [2], aw_lead [2];

  int n_tests = 0, n_fail = 0;
  int rd_target = NONE, wr_target = NONE;
  logic [31:0] rd_addr_exp, wr_addr_exp, wr_data_exp;
  logic [7:0]  wr_strb_exp;
  rd_ent_t rd_log[$];
  wr_ent_t wr_log[$];

  ysyx_25030093_xbar dut (
    .clk(clk), .rst_n(rst_n),
    .M_araddr(M_araddr), .M_arvalid(M_arvalid), .M_arready(M_arready),
    .M_rdata(M_rdata), .M_rresp(M_rresp), .M_rvalid(M_rvalid), .M_rready(M_rready),
    .M_awaddr(M_awaddr), .M_awvalid(M_awvalid), .M_awready(M_awready),
    .M_wdata(M_wdata), .M_wstrb(M_wstrb), .M_wvalid(M_wvalid), .M_wready(M_wready),
    .M_bresp(M_bresp), .M_bvalid(M_bvalid), .M_bready(M_bready),
    .UART_araddr(s_araddr[0]), .UART_arvalid(s_arvalid[0]), .UART_arready(s_arready[0]),
    .UART_rdata(s_rdata[0]), .UART_rvalid(s_rvalid[0]), .UART_rready(s_rready[0]),
    .UART_awaddr(s_awaddr[0]), .UART_awvalid(s_awvalid[0]), .UART_awready(s_awready[0]),
    .UART_wdata(s_wdata[0]), .UART_wstrb(s_wstrb[0]), .UART_wvalid(s_wvalid[0]),
    .UART_wready(s_wready[0]), .UART_bvalid(s_bvalid[0]), .UART_bready(s_bready[0]),
    .SRAM_araddr(s_araddr[1]), .SRAM_arvalid(s_arvalid[1]), .SRAM_arready(s_arready[1]),
    .SRAM_rdata(s_rdata[1]), .SRAM_rvalid(s_rvalid[1]), .SRAM_rready(s_rready[1]),
    .SRAM_awaddr(s_awaddr[1]), .SRAM_awvalid(s_awvalid[1]), .SRAM_awready(s_awready[1]),
    .SRAM_wdata(s_wdata[1]), .SRAM_wstrb(s_wstrb[1]), .SRAM_wvalid(s_wvalid[1]),
    .SRAM_wready(s_wready[1]), .SRAM_bvalid(s_bvalid[1]), .SRAM_bready(s_bready[1])
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check(input bit ok, input string name, input logic [31:0] act, input logic [31:0] exp);
    n_tests++;
    if (!ok) begin
      n_fail++;
      $display("FAIL %s: got %h, want %h (t=%0t)", name, act, exp, $time);
    end
  endtask

  // Address map from the documented windows; 0 = UART, 1 = SRAM, 2 = decode error
  function automatic int target_of(input logic [31:0] a);
    longint unsigned x;
    x = 64'(a);
    if (x >= 64'ha000_03f8 && x < 64'ha000_0400) return 0;
    if (x >= 64'h8000_0000 && x < 64'h8800_0000) return 1;
    return ERR;
  endfunction

  function automatic logic [31:0] rd_val(input int id, input logic [31:0] a);
    return (id == 0) ? (a ^ 32'h0f0f_0f0f) : (a ^ 32'h9234_5668);
  endfunction

  function automatic logic [31:0] rand_addr();
    case ($urandom_range(0, 3))
      0: return 32'ha000_03f8 + 32'($urandom_range(0, 7));
      1: return 32'h8000_0000 + ($urandom & 32'h07ff_fffc);
      2: return $urandom;
      default: return 32'ha000_03f0 + 32'($urandom_range(0, 31));
    endcase
  endfunction

  task automatic slave_agent(input int id);
    bit rd_pend, aw_got, w_got, b_pend;
    int rd_dly, b_dly;
    logic [31:0] rd_a, wa, wd;
    logic [7:0] ws;
    rd_ent_t re;
    wr_ent_t we;
    rd_pend = 0; aw_got = 0; w_got = 0; b_pend = 0; rd_dly = 0; b_dly = 0;
    rd_a = '0; wa = '0; wd = '0; ws = '0;
    forever begin
      @(negedge clk);
      s_arready[id] = !rd_pend && !stall_ar[id] && ($urandom_range(0, 2) != 0);
      s_rvalid[id]  = rd_pend && (rd_dly == 0);
      s_rdata[id]   = s_rvalid[id] ? rd_val(id, rd_a) : $urandom;
      if (aw_lead[id]) begin
        s_awready[id] = !aw_got && !b_pend;
        s_wready[id]  = aw_got && !w_got;
      end else begin
        s_awready[id] = !aw_got && !b_pend && ($urandom_range(0, 1) != 0);
        s_wready[id]  = !w_got && !b_pend && ($urandom_range(0, 1) != 0);
      end
      s_bvalid[id] = b_pend && (b_dly == 0);
      #3;
      if (!rst_n) begin
        rd_pend = 0; aw_got = 0; w_got = 0; b_pend = 0;
      end else begin
        if (s_rvalid[id] && s_rready[id]) rd_pend = 0;
        else if (rd_pend && rd_dly > 0) rd_dly--;
        if (s_arvalid[id] && s_arready[id]) begin
          rd_pend = 1; rd_a = s_araddr[id]; rd_dly = $urandom_range(0, 2);
          re.id = (id == 1); re.addr = rd_a;
          rd_log.push_back(re);
        end
        if (s_bvalid[id] && s_bready[id]) b_pend = 0;
        else if (b_pend && b_dly > 0) b_dly--;
        if (s_awvalid[id] && s_awready[id]) begin aw_got = 1; wa = s_awaddr[id]; end
        if (s_wvalid[id] && s_wready[id]) begin w_got = 1; wd = s_wdata[id]; ws = s_wstrb[id]; end
        if (aw_got && w_got) begin
          we.id = (id == 1); we.addr = wa; we.data = wd; we.strb = ws;
          wr_log.push_back(we);
          b_pend = 1; b_dly = $urandom_range(0, 2); aw_got = 0; w_got = 0;
        end
      end
    end
  endtask

  task automatic do_read(input logic [31:0] addr, input int hold,
                         output logic [31:0] data, output logic [1:0] resp);
    int tgt, n0, held;
    bit acc, got, seen;
    logic [31:0] first_d;
    tgt = target_of(addr); n0 = rd_log.size();
    acc = 0; got = 0; seen = 0; held = 0; first_d = '0; data = '0; resp = '0;
    @(negedge clk);
    M_arvalid = 1'b1; M_araddr = addr;
    for (int c = 0; c < 100 && !acc; c++) begin
      #3;
      acc = M_arready;
      if (acc) begin rd_target = tgt; rd_addr_exp = addr; end
      @(negedge clk);
    end
    M_arvalid = 1'b0; M_araddr = $urandom;
    check(acc, "ar_accept", 32'(acc), 32'd1);
    for (int c = 0; c < 200 && acc && !got; c++) begin
      M_rready = (held >= hold) && (hold > 0 || $urandom_range(0, 2) != 0);
      #3;
      if (seen) check(M_rvalid && M_rdata == first_d, "r_stable", M_rdata, first_d);
      if (M_rvalid) begin
        if (!seen) begin seen = 1; first_d = M_rdata; end
        if (M_rready) begin got = 1; data = M_rdata; resp = M_rresp; rd_target = NONE; end
        else held++;
      end
      @(negedge clk);
    end
    M_rready = 1'b0;
    check(got, "r_done", 32'(got), 32'd1);
    if (tgt == ERR) begin
      check(data == 32'h0 && resp == 2'b11, "r_decerr", {data[29:0], resp}, 32'h3);
      check(rd_log.size() == n0, "r_err_untouched", 32'(rd_log.size()), 32'(n0));
    end else begin
      check(data == rd_val(tgt, addr) && resp == 2'b00, "r_data", data, rd_val(tgt, addr));
      check(rd_log.size() == n0 + 1 && rd_log[n0].id == (tgt == 1) && rd_log[n0].addr == addr,
            "r_routed", 32'(rd_log.size() - n0), 32'd1);
    end
  endtask

  task automatic do_write(input logic [31:0] addr, input logic [31:0] data,
                          input logic [7:0] strb, output logic [1:0] resp);
    int tgt, n0;
    bit acc, got;
    tgt = target_of(addr); n0 = wr_log.size(); acc = 0; got = 0; resp = '0;
    @(negedge clk);
    M_awvalid = 1'b1; M_wvalid = 1'b1; M_awaddr = addr; M_wdata = data; M_wstrb = strb;
    for (int c = 0; c < 100 && !acc; c++) begin
      #3;
      check(M_awready == M_wready, "aw_w_ready_pair", 32'(M_awready), 32'(M_wready));
      acc = M_awready;
      if (acc) begin
        wr_target = tgt; wr_addr_exp = addr; wr_data_exp = data; wr_strb_exp = strb;
      end
      @(negedge clk);
    end
    M_awvalid = 1'b0; M_wvalid = 1'b0;
    check(acc, "aw_accept", 32'(acc), 32'd1);
    for (int c = 0; c < 200 && acc && !got; c++) begin
      M_bready = ($urandom_range(0, 2) != 0);
      #3;
      if (M_bvalid && M_bready) begin got = 1; resp = M_bresp; wr_target = NONE; end
      @(negedge clk);
    end
    M_bready = 1'b0;
    check(got, "b_done", 32'(got), 32'd1);
    if (tgt == ERR) begin
      check(resp == 2'b11, "b_decerr", 32'(resp), 32'h3);
      check(wr_log.size() == n0, "w_err_untouched", 32'(wr_log.size()), 32'(n0));
    end else begin
      check(resp == 2'b00, "b_okay", 32'(resp), 32'h0);
      check(wr_log.size() == n0 + 1 && wr_log[n0].id == (tgt == 1) && wr_log[n0].addr == addr &&
            wr_log[n0].data == data && wr_log[n0].strb == strb,
            "w_routed", 32'(wr_log.size() - n0), 32'd1);
    end
  endtask

  // Per-cycle checks: unselected slaves idle, forwarded fields, no unexpected responses
  initial begin
    forever begin
      @(negedge clk);
      #2;
      if (!rst_n)
        check(!M_arready && !M_awready && !M_wready && !M_rvalid && !M_bvalid,
              "reset_outputs", {M_arready, M_awready, M_wready, M_rvalid, M_bvalid}, 32'h0);
      for (int i = 0; i < 2; i++) begin
        if (rd_target != i) check(!s_arvalid[i] && !s_rready[i], "rd_unsel_idle", 32'(i), 32'(rd_target));
        else if (s_arvalid[i]) check(s_araddr[i] == rd_addr_exp, "araddr_fwd", s_araddr[i], rd_addr_exp);
        if (wr_target != i)
          check(!s_awvalid[i] && !s_wvalid[i] && !s_bready[i], "wr_unsel_idle", 32'(i), 32'(wr_target));
        else begin
          if (s_awvalid[i]) check(s_awaddr[i] == wr_addr_exp, "awaddr_fwd", s_awaddr[i], wr_addr_exp);
          if (s_wvalid[i])
            check(s_wdata[i] == wr_data_exp && s_wstrb[i] == wr_strb_exp, "wdata_fwd", s_wdata[i], wr_data_exp);
        end
      end
      if (rd_target == NONE) check(!M_rvalid, "no_spurious_rvalid", 32'(M_rvalid), 32'h0);
      if (wr_target == NONE) check(!M_bvalid, "no_spurious_bvalid", 32'(M_bvalid), 32'h0);
    end
  end

  initial begin
    #300000;
    $display("FAIL watchdog: got timeout, want completion");
    $fatal(1, "watchdog");
  end

  logic [31:0] rd_d;
  logic [1:0]  rd_r, wr_r;

  initial begin
    rst_n = 1'b0;
    M_araddr = '0; M_arvalid = 0; M_rready = 0; M_awaddr = '0; M_awvalid = 0;
    M_wdata = '0; M_wstrb = '0; M_wvalid = 0; M_bready = 0;
    for (int i = 0; i < 2; i++) begin
      stall_ar[i] = 0; aw_lead[i] = 0;
      s_arready[i] = 0; s_rvalid[i] = 0; s_rdata[i] = '0;
      s_awready[i] = 0; s_wready[i] = 0; s_bvalid[i] = 0;
    end
    fork
      slave_agent(0);
      slave_agent(1);
    join_none
    M_arvalid = 1; M_awvalid = 1; M_wvalid = 1;
    repeat (3) @(negedge clk);
    #2;
    check(M_arready === 1'b0, "rst_arready", 32'(M_arready), 32'h0);
    check(M_awready === 1'b0 && M_wready === 1'b0, "rst_awready", 32'(M_awready), 32'h0);
    check(M_rvalid === 1'b0 && M_bvalid === 1'b0, "rst_valids", 32'(M_rvalid), 32'h0);
    check(M_rdata === 32'h0 && M_rresp === 2'b00 && M_bresp === 2'b00, "rst_data", M_rdata, 32'h0);
    M_arvalid = 0; M_awvalid = 0; M_wvalid = 0;
    @(negedge clk);
    rst_n = 1'b1;

    do_read(32'h8000_0010, 0, rd_d, rd_r);
    check(rd_d == 32'h1234_5678 && rd_r == 2'b00, "sram_read_lit", rd_d, 32'h1234_5678);

    aw_lead[0] = 1;
    do_write(32'ha000_03f8, 32'h41, 8'h01, wr_r);
    aw_lead[0] = 0;
    check(wr_r == 2'b00, "uart_write_lit", 32'(wr_r), 32'h0);

    do_read(32'h0000_0000, 0, rd_d, rd_r);
    check(rd_d == 32'h0 && rd_r == 2'b11, "decerr_read_lit", {rd_d[29:0], rd_r}, 32'h3);

    do_read(32'h8000_0100, 3, rd_d, rd_r);

    fork
      do_read(32'h8000_0020, 0, rd_d, rd_r);
      do_write(32'ha000_03fc, 32'hdead_beef, 8'h0f, wr_r);
    join

    do_read(32'ha000_03ff, 0, rd_d, rd_r);
    check(rd_d == 32'haf0f_0cf0 && rd_r == 2'b00, "uart_top_lit", rd_d, 32'haf0f_0cf0);
    do_read(32'ha000_0400, 0, rd_d, rd_r);
    check(rd_r == 2'b11, "uart_past_end_lit", 32'(rd_r), 32'h3);
    do_read(32'h87ff_fffc, 0, rd_d, rd_r);
    check(rd_r == 2'b00, "sram_top_lit", 32'(rd_r), 32'h0);
    do_read(32'h8800_0000, 0, rd_d, rd_r);
    check(rd_r == 2'b11, "sram_past_end_lit", 32'(rd_r), 32'h3);
    do_read(32'h7fff_fffc, 0, rd_d, rd_r);
    do_write(32'h0000_1000, 32'h5555_aaaa, 8'hff, wr_r);
    check(wr_r == 2'b11, "decerr_write_lit", 32'(wr_r), 32'h3);

    stall_ar[1] = 1;
    @(negedge clk);
    M_arvalid = 1; M_araddr = 32'h8000_0040;
    #3;
    check(M_arready, "rst_ar_accept", 32'(M_arready), 32'h1);
    rd_target = 1; rd_addr_exp = 32'h8000_0040;
    @(negedge clk);
    M_arvalid = 0;
    #3;
    check(s_arvalid[1], "sram_arvalid_before_rst", 32'(s_arvalid[1]), 32'h1);
    #1;
    rst_n = 1'b0;
    rd_target = NONE;
    #1;
    check(!s_arvalid[1], "sram_arvalid_drop", 32'(s_arvalid[1]), 32'h0);
    repeat (2) @(negedge clk);
    rst_n = 1'b1;
    stall_ar[1] = 0;
    M_rready = 1;
    for (int c = 0; c < 6; c++) begin
      #3;
      check(!M_rvalid && !s_arvalid[1], "no_resp_after_rst", 32'(M_rvalid), 32'h0);
      @(negedge clk);
    end
    M_rready = 0;

    for (int k = 0; k < 40; k++) begin
      fork
        do_read(rand_addr(), $urandom_range(0, 2), rd_d, rd_r);
        do_write(rand_addr(), $urandom, 8'($urandom), wr_r);
      join
    end

    repeat (3) @(negedge clk);
    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule

// File: doc/ysyx_25030093_xbar.md
YSYX_25030093_XBAR -- requirements
Module: ysyx_25030093_xbar

Interface
REQ-001: Parameter UART_BASE, 32'ha000_03f8, first byte of the UART window.
REQ-002: Parameter UART_SIZE, 32'h8, byte length of the UART window.
REQ-003: Parameter SRAM_BASE, 32'h8000_0000, first byte of the SRAM window.
REQ-004: Parameter SRAM_SIZE, 32'h0800_0000, byte length of the SRAM window.
REQ-005: clk  in  1  single clock; all state updates on the rising edge.
REQ-006: rst_n  in  1  reset, asynchronous, active-low.
REQ-007: M_ar: M_araddr in 32, M_arvalid in 1, M_arready out 1 (master read address).
REQ-008: M_r: M_rdata out 32, M_rresp out 2, M_rvalid out 1, M_rready in 1 (master read data).
REQ-009: M_aw: M_awaddr in 32, M_awvalid in 1, M_awready out 1 (master write address).
REQ-010: M_w: M_wdata in 32, M_wstrb in 8, M_wvalid in 1, M_wready out 1 (master write data).
REQ-011: M_b: M_bresp out 2, M_bvalid out 1, M_bready in 1 (master write response).
REQ-012: The UART_* and SRAM_* slave ports SHALL mirror the five channels with directions inverted, same names and widths, and no resp signals.

Function
REQ-013: Decode SHALL be BASE <= addr < BASE+SIZE; UART wins on overlap; no hit means DECERR.
REQ-014: Read FSM states SHALL be R_IDLE, R_ADDR, R_DATA, R_ERR; one outstanding read.
REQ-015: In R_IDLE, M_arready SHALL be 1; on M_arvalid&M_arready, latch address and target, go to R_ADDR (hit) or R_ERR (miss).
REQ-016: In R_ADDR, the selected slave arvalid SHALL be 1 with the latched address until its arready is sampled 1, then go to R_DATA.
REQ-017: In R_DATA, M_rvalid/M_rdata SHALL pass combinationally from the selected slave, M_rresp=2'b00, slave rready=M_rready; on rvalid&rready, go to R_IDLE.
REQ-018: In R_ERR, M_rvalid=1, M_rdata=0, M_rresp=2'b11 SHALL hold until M_rready, then go to R_IDLE.
REQ-019: Write FSM states SHALL be W_IDLE, W_FWD, W_RESP, W_ERR; one outstanding write, independent of the read FSM.
REQ-020: In W_IDLE, M_awready and M_wready SHALL both be 1 only when M_awvalid&M_wvalid; on that cycle, latch addr/data/strb/target.
REQ-021: In W_FWD, slave awvalid and wvalid SHALL each drop independently after their own ready (aw_done/w_done flags); when both are done, go to W_RESP.
REQ-022: In W_RESP, slave bvalid SHALL pass to M_bvalid with M_bresp=2'b00 and slave bready=M_bready; on handshake, go to W_IDLE.
REQ-023: In W_ERR, M_bvalid=1 and M_bresp=2'b11 SHALL hold until M_bready; no slave is touched.
REQ-024: The unselected slave SHALL see all valids/readies at 0 throughout.
REQ-025: A read and a write to the same slave SHALL proceed concurrently without interlock.
REQ-026: Minimum latency SHALL be accept -> slave request on the next cycle; no combinational path from M_*valid to slave valids.

Reset
REQ-027: When rst_n=0 (asynchronously), both FSMs SHALL return to IDLE, aw_done/w_done clear, and all valid outputs go to 0.
REQ-028: While in reset, M_arready and M_awready/M_wready SHALL be 0, and data/resp outputs 0.
REQ-029: Reset mid-transaction SHALL abandon the transaction, and no response SHALL be issued for it after release.

Structure
REQ-030: A shared package ysyx_25030093_axi_pkg SHALL hold the state enums, the RESP_OKAY/RESP_DECERR constants, and the address-map defaults.
REQ-031: The address decoder SHALL be one sub-module, ysyx_25030093_xbar_dec (addr -> sel_uart, sel_sram, err), instanced twice (read, write).

Verification
REQ-032: Read 0x8000_0010, SRAM returns 0x1234_5678 -> M_rdata=0x1234_5678, rresp=00, UART signals idle.
REQ-033: Write 0xa000_03f8, wdata=0x41, strb=0x01, UART awready one cycle before wready -> single UART write, then M_bvalid with bresp=00.
REQ-034: Read 0x0000_0000 -> M_rvalid with rdata=0, rresp=11, both slaves untouched.
REQ-035: M_rready held 0 for 3 cycles in R_DATA -> M_rvalid and data stable, FSM stays in R_DATA.
REQ-036: Concurrent read of SRAM and write of UART -> both complete, correct routing.
REQ-037: rst_n pulsed low during R_ADDR -> SRAM_arvalid drops immediately, and no M_rvalid after release.
